power_spectrum_buffer: RTL

//  Stage directly upstream of MEL. Accepts one streamed FFT frame of complex bins.

---
 rtl/mfcc_pkg.sv | 23 ++
 rtl/power_spectrum_buffer_power_calc.sv | 69 ++++++
 rtl/power_spectrum_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mfcc_pkg.sv
// Shared constants and types for the MFCC front end: FFT framing, power widths
// and the power_spectrum_buffer state encoding.
package mfcc_pkg;

    localparam int FFT_LEN = 512;
    localparam int NFFT    = 257;
    localparam int DATA_W  = 16;
    localparam int PWR_W   = 32;

    localparam int BIN_W  = $clog2(FFT_LEN);
    localparam int ADDR_W = $clog2(NFFT);
    localparam int PTR_W  = $clog2(NFFT) + 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        START = 2'd2,
        SERVE = 2'd3
    } psb_state_t;

    typedef logic [PWR_W-1:0] power_t;

endpackage

// File: rtl/power_spectrum_buffer_power_calc.sv
// Two-stage |X|^2 pipeline: stage 1 squares the real and imaginary parts,
// stage 2 sums, shifts and truncates; valid and bin index ride alongside.
module power_calc
    import mfcc_pkg::*;
#(
    parameter int PWR_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic [BIN_W-1:0]  in_bin,
    output logic              out_valid,
    output logic [BIN_W-1:0]  out_bin,
    output power_t            out_power
);

    localparam int SQ_W  = 2 * DATA_W;
    localparam int SUM_W = SQ_W + 1;

    logic [SQ_W-1:0]  re_ext_s;
    logic [SQ_W-1:0]  im_ext_s;
    logic [SQ_W-1:0]  sq_re_s;
    logic [SQ_W-1:0]  sq_im_s;
    logic [SQ_W-1:0]  sq_re_r;
    logic [SQ_W-1:0]  sq_im_r;
    logic             valid_s1_r;
    logic [BIN_W-1:0] bin_s1_r;
    logic [SUM_W-1:0] sum_s;
    logic [SUM_W-1:0] shifted_s;

    // The low SQ_W bits of the sign-extended product are the exact square.
    assign re_ext_s  = {{DATA_W{in_re[DATA_W-1]}}, in_re};
    assign im_ext_s  = {{DATA_W{in_im[DATA_W-1]}}, in_im};
    assign sq_re_s   = re_ext_s * re_ext_s;
    assign sq_im_s   = im_ext_s * im_ext_s;
    assign sum_s     = {1'b0, sq_re_r} + {1'b0, sq_im_r};
    assign shifted_s = sum_s >> PWR_SHIFT;

    // Stage 1: register the two squares with their side-band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1_r <= 1'b0;
            bin_s1_r   <= {BIN_W{1'b0}};
            sq_re_r    <= {SQ_W{1'b0}};
            sq_im_r    <= {SQ_W{1'b0}};
        end else begin
            valid_s1_r <= in_valid;
            bin_s1_r   <= in_bin;
            sq_re_r    <= sq_re_s;
            sq_im_r    <= sq_im_s;
        end
    end

    // Stage 2: register the shifted, truncated power with its side-band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bin   <= {BIN_W{1'b0}};
            out_power <= {PWR_W{1'b0}};
        end else begin
            out_valid <= valid_s1_r;
            out_bin   <= bin_s1_r;
            out_power <= shifted_s[PWR_W-1:0];
        end
    end

endmodule

// File: rtl/power_spectrum_buffer.sv
// Collects one FFT frame's bin powers into a RAM, announces it to MEL with a
// start pulse and serves MEL's pointer reads until MEL reports done.
module power_spectrum_buffer
    import mfcc_pkg::*;
#(
    parameter int PWR_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fft_valid_i,
    output logic              fft_ready_o,
    input  logic [DATA_W-1:0] fft_real_i,
    input  logic [DATA_W-1:0] fft_imag_i,
    input  logic              fft_last_i,
    output logic              mel_start_o,
    input  logic              mel_done_i,
    input  logic [PTR_W-1:0]  prt_power_spectrum_frame,
    output power_t            value_power_spectrum_frame,
    output logic              frame_err_o
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);
    localparam logic [BIN_W-1:0] KEEP_BIN = BIN_W'(NFFT);
    localparam logic [PTR_W-1:0] NFFT_PTR = PTR_W'(NFFT);

    psb_state_t       state_r;
    psb_state_t       next_state_s;
    logic [BIN_W-1:0] bin_cnt_r;
    logic             drain_cnt_r;
    logic             ready_r;
    logic             start_r;
    logic             err_r;
    power_t           rd_data_r;
    power_t           ram [0:NFFT-1];

    logic             accept_s;
    logic             is_last_bin_s;
    logic             good_last_s;
    logic             bad_frame_s;
    logic             pc_in_valid_s;
    logic             pc_valid_s;
    logic [BIN_W-1:0] pc_bin_s;
    power_t           pc_power_s;

    assign accept_s      = fft_valid_i & ready_r;
    assign is_last_bin_s = (bin_cnt_r == LAST_BIN);
    assign good_last_s   = accept_s & fft_last_i & is_last_bin_s;
    assign bad_frame_s   = accept_s & (fft_last_i ^ is_last_bin_s);
    assign pc_in_valid_s = accept_s & (bin_cnt_r < KEEP_BIN);

    assign fft_ready_o                = ready_r;
    assign mel_start_o                = start_r;
    assign frame_err_o                = err_r;
    assign value_power_spectrum_frame = rd_data_r;

    power_calc #(
        .PWR_SHIFT (PWR_SHIFT)
    ) u_power_calc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (pc_in_valid_s),
        .in_re     (fft_real_i),
        .in_im     (fft_imag_i),
        .in_bin    (bin_cnt_r),
        .out_valid (pc_valid_s),
        .out_bin   (pc_bin_s),
        .out_power (pc_power_s)
    );

    // Next-state decode; DRAIN lasts two cycles so the pipeline empties.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FILL: begin
                if (good_last_s) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = FILL;
                end
            end
            DRAIN: begin
                if (drain_cnt_r) begin
                    next_state_s = START;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            START: next_state_s = SERVE;
            SERVE: begin
                if (mel_done_i) begin
                    next_state_s = FILL;
                end else begin
                    next_state_s = SERVE;
                end
            end
            default: next_state_s = FILL;
        endcase
    end

    // State, counters and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            bin_cnt_r   <= {BIN_W{1'b0}};
            drain_cnt_r <= 1'b0;
            ready_r     <= 1'b0;
            start_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            ready_r     <= (next_state_s == FILL);
            start_r     <= (next_state_s == START);
            err_r       <= bad_frame_s;
            drain_cnt_r <= (state_r == DRAIN) ? ~drain_cnt_r : 1'b0;
            if (good_last_s || bad_frame_s) begin
                bin_cnt_r <= {BIN_W{1'b0}};
            end else if (accept_s) begin
                bin_cnt_r <= bin_cnt_r + {{(BIN_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Power RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (pc_valid_s) begin
            ram[pc_bin_s[ADDR_W-1:0]] <= pc_power_s;
        end
    end

    // Registered read port; out-of-range pointers read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {PWR_W{1'b0}};
        end else if (prt_power_spectrum_frame < NFFT_PTR) begin
            rd_data_r <= ram[prt_power_spectrum_frame[ADDR_W-1:0]];
        end else begin
            rd_data_r <= {PWR_W{1'b0}};
        end
    end

endmodule
